mem_stage: RTL

//  MEM stage of the 5-stage MIPS pipeline. Sits between EX/MEM buffer outputs and MEM/WB buffer inputs.
//  - Performs data-memory loads/stores; a load takes a configurable multi-cycle latency and stalls the pipe.
//  - Resolves branches as PCSrc = Branch & Zero.
//  - Forwards writeback control and data to MEM/WB, inserting a bubble while stalled.

---
 rtl/mips_pkg.sv | 13 +
 rtl/dmem_array.sv | 24 ++
 rtl/mem_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and widths.
package mips_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data memory: synchronous write, combinational read, contents not reset.
module dmem_array #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned WORD_W     = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WORD_W-1:0]     wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WORD_W-1:0]     rdata
);

   logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data memory access with multi-cycle load stall, branch resolve, WB pass-through.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RegWrite_in,
   input  logic                  MemtoReg_in,
   input  logic                  MemRead_in,
   input  logic                  MemWrite_in,
   input  logic                  Branch_in,
   input  logic                  Zero_in,
   input  logic [WORD_W-1:0]     alu_result_in,
   input  logic [WORD_W-1:0]     write_data_in,
   input  logic [REG_ADDR_W-1:0] write_reg_in,
   output logic                  stall,
   output logic                  PCSrc,
   output logic                  RegWrite_out,
   output logic                  MemtoReg_out,
   output logic [WORD_W-1:0]     read_data_out,
   output logic [WORD_W-1:0]     alu_result_out,
   output logic [REG_ADDR_W-1:0] write_reg_out,
   output logic                  misalign
);

   localparam bit         MULTI_CYCLE = (READ_LATENCY != 0);
   localparam logic [3:0] CNT_INIT    = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

   mem_state_t            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr, addr_q, raddr;
   logic [WORD_W-1:0]     rdata_q, rdata_d, mem_rdata;
   logic                  access_misaligned;
   logic                  load_start;
   logic                  stall_int;
   logic                  mem_we;

   assign addr = alu_result_in[ADDR_WIDTH+1:2];

`ifdef MEM_ALIGN_CHECK_EN
   assign access_misaligned = (MemRead_in | MemWrite_in) & (alu_result_in[1:0] != 2'b00);
`else
   assign access_misaligned = 1'b0;
`endif

   // Loads win over stores when both are requested.
   assign mem_we = MemWrite_in & ~MemRead_in & ~access_misaligned & (state_q == IDLE);
   assign raddr  = (state_q == BUSY) ? addr_q : addr;

   dmem_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_W     (WORD_W)
   ) u_dmem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (addr),
      .wdata (write_data_in),
      .raddr (raddr),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      load_start = 1'b0;
      stall_int  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (MULTI_CYCLE && MemRead_in && !access_misaligned) begin
               load_start = 1'b1;
               stall_int  = 1'b1;
               cnt_d      = CNT_INIT;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            stall_int = 1'b1;
            if (cnt_q == 4'd0) begin
               rdata_d = mem_rdata;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         if (load_start) begin
            addr_q <= addr;
         end
      end
   end

   // Reset overrides the Mealy stall so upstream is released immediately.
   assign stall    = stall_int & ~reset;
   assign misalign = access_misaligned & ~reset;

   always_comb begin
      read_data_out = '0;
      if (MULTI_CYCLE) begin
         if (state_q == DONE) begin
            read_data_out = rdata_q;
         end
      end else if (MemRead_in && !access_misaligned) begin
         read_data_out = mem_rdata;
      end
   end

   assign PCSrc          = Branch_in & Zero_in;
   assign RegWrite_out   = RegWrite_in & ~stall & ~access_misaligned;
   assign MemtoReg_out   = MemtoReg_in;
   assign alu_result_out = alu_result_in;
   assign write_reg_out  = write_reg_in;

endmodule
